// File: rtl/mmio_byte_bridge.sv
// Serialises one 32-bit CPU word access into single-cycle byte beats for the
// byte-wide MMIO peripherals, and reassembles read bytes into a word.
module mmio_byte_bridge #(
  parameter logic [31:0] MMIO_BASE = 32'h2000_0000,
  parameter logic [31:0] MMIO_SIZE = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mmio_addr,
  output logic [7:0]  o_mmio_wdata,
  input  logic [7:0]  i_mmio_rdata,
  output logic        o_mmio_we,
  output logic        o_mmio_re
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] addr_q, wdata_q, rdata_q, mmio_addr_q;
  logic [7:0]  mmio_wdata_q;
  logic [3:0]  be_q, higher;
  logic [1:0]  lane_q, next_lane;
  logic        we_q, err_q;
  logic        accept, in_range, load_beat;
  logic [31:0] word_addr, beat_base, beat_src;
  logic        beat_we;
  logic [32:0] win_end;

  assign word_addr = i_addr & ~32'h0000_0003;
  // 33-bit window bound so a window ending exactly at 2^32 does not wrap.
  assign win_end   = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};
  assign in_range  = ({1'b0, word_addr} >= {1'b0, MMIO_BASE}) &&
                     ({1'b0, word_addr} < win_end);
  assign accept    = (state == IDLE) && i_req;

  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_lane  = lane_q;
    load_beat  = 1'b0;
    higher     = be_q & (4'b1110 << lane_q);
    o_ready    = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    o_mmio_we  = 1'b0;
    o_mmio_re  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req) begin
          if (!in_range || i_be == 4'h0) begin
            next_state = DONE;
          end else begin
            next_state = BEAT;
            next_lane  = lowest_lane(i_be);
            load_beat  = 1'b1;
          end
        end
      end
      BEAT: begin
        o_mmio_we = we_q;
        o_mmio_re = ~we_q;
        if (higher == 4'h0) begin
          next_state = DONE;
        end else begin
          next_lane = lowest_lane(higher);
          load_beat = 1'b1;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        o_err      = err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The first beat is set up from the request inputs, later beats from the latched copy.
  assign beat_base = (state == IDLE) ? word_addr : addr_q;
  assign beat_src  = (state == IDLE) ? i_wdata   : wdata_q;
  assign beat_we   = (state == IDLE) ? i_we      : we_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      lane_q       <= '0;
      rdata_q      <= '0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
    end else begin
      lane_q <= next_lane;
      if (accept) begin
        addr_q  <= word_addr;
        wdata_q <= i_wdata;
        be_q    <= i_be;
        we_q    <= i_we;
        err_q   <= ~in_range;
        rdata_q <= '0;
      end
      if (state == BEAT && !we_q) rdata_q[{lane_q, 3'b000} +: 8] <= i_mmio_rdata;
      // Bus address/data only move when a beat is issued; otherwise they hold.
      if (load_beat) begin
        mmio_addr_q  <= beat_base + {30'b0, next_lane};
        mmio_wdata_q <= beat_we ? beat_src[{next_lane, 3'b000} +: 8] : 8'h00;
      end
    end
  end

  assign o_rdata      = rdata_q;
  assign o_mmio_addr  = mmio_addr_q;
  assign o_mmio_wdata = mmio_wdata_q;

endmodule

// File: tb/tb_mmio_byte_bridge.sv
// Self-checking bench for mmio_byte_bridge: directed test-plan cases plus
// randomized word accesses compared against a transaction-level model.
module tb_mmio_byte_bridge;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_req, i_we;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_be;
  logic        o_ready, o_done, o_err;
  logic [31:0] o_rdata, o_mmio_addr;
  logic [7:0]  o_mmio_wdata, i_mmio_rdata;
  logic        o_mmio_we, o_mmio_re;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] periph_mem [0:4095];

  mmio_byte_bridge #(.MMIO_BASE(BASE), .MMIO_SIZE(SIZE)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
    .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_mmio_addr(o_mmio_addr), .o_mmio_wdata(o_mmio_wdata),
    .i_mmio_rdata(i_mmio_rdata), .o_mmio_we(o_mmio_we), .o_mmio_re(o_mmio_re)
  );

  always #5 i_clk = ~i_clk;

  // Peripheral: byte array answering combinationally while the read strobe is high.
  assign i_mmio_rdata = o_mmio_re ? periph_mem[o_mmio_addr[11:0]] : 8'hEE;

  function automatic bit in_window(input logic [31:0] w);
    return ({32'b0, w} >= {32'b0, BASE}) && ({32'b0, w} < {32'b0, BASE} + {32'b0, SIZE});
  endfunction

  // One full transaction: accept in cycle T, then check every following cycle
  // against the lane list and read word derived from the access rules.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input string name);
    logic [31:0] word, exp_rdata, cur;
    bit          ok_win;
    int          lanes[$];
    word      = {addr[31:2], 2'b00};
    ok_win    = in_window(word);
    exp_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (ok_win && be[k]) begin
        lanes.push_back(k);
        cur = word + 32'(k);
        if (!we) exp_rdata[8*k +: 8] = periph_mem[cur[11:0]];
      end
    end
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_before: got ready=%b done=%b want 1 0", name, o_ready, o_done);
    end
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_be = be;
    @(negedge i_clk);
    i_req = 1'b0; i_addr = $urandom; i_wdata = $urandom; i_be = 4'($urandom); i_we = ~we;
    foreach (lanes[j]) begin
      cur = word + 32'(lanes[j]);
      n_checks++;
      if (o_mmio_we !== we || o_mmio_re !== !we || o_mmio_addr !== cur || o_done !== 1'b0 ||
          o_ready !== 1'b0 || o_mmio_wdata !== (we ? wdata[8*lanes[j] +: 8] : 8'h00)) begin
        n_fail++;
        $display("FAIL %s beat%0d: got we=%b re=%b addr=%h wdata=%h done=%b want we=%b re=%b addr=%h wdata=%h done=0",
                 name, j, o_mmio_we, o_mmio_re, o_mmio_addr, o_mmio_wdata, o_done, we, !we, cur,
                 we ? wdata[8*lanes[j] +: 8] : 8'h00);
      end
      @(negedge i_clk);
    end
    n_checks++;
    if (o_done !== 1'b1 || o_err !== !ok_win || o_rdata !== exp_rdata ||
        o_mmio_we !== 1'b0 || o_mmio_re !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: got done=%b err=%b rdata=%h we=%b re=%b want done=1 err=%b rdata=%h we=0 re=0",
               name, o_done, o_err, o_rdata, o_mmio_we, o_mmio_re, !ok_win, exp_rdata);
    end
  endtask

  task automatic test_reset;
    i_rstn = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
    #12;
    n_checks++;
    if (o_done !== 1'b0 || o_err !== 1'b0 || o_mmio_we !== 1'b0 || o_mmio_re !== 1'b0 ||
        o_rdata !== 32'h0 || o_mmio_addr !== 32'h0 || o_mmio_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b we=%b re=%b rdata=%h addr=%h wdata=%h want all 0",
               o_done, o_err, o_mmio_we, o_mmio_re, o_rdata, o_mmio_addr, o_mmio_wdata);
    end
    @(negedge i_clk); i_rstn = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_store_full;
    do_txn(1'b1, 32'h2000_0000, 32'hDDCC_BBAA, 4'hF, "store_full");
  endtask

  task automatic test_load_single;
    periph_mem[4] = 8'h5A;
    do_txn(1'b0, 32'h2000_0004, 32'h0, 4'h1, "load_single");
  endtask

  task automatic test_load_sparse;
    periph_mem[0] = 8'h11; periph_mem[1] = 8'h77; periph_mem[2] = 8'h33; periph_mem[3] = 8'h99;
    do_txn(1'b0, 32'h2000_0003, 32'h0, 4'b0101, "load_sparse");
    n_checks++;
    if (o_rdata !== 32'h0033_0011) begin
      n_fail++; $display("FAIL load_sparse_word: got %h want 00330011", o_rdata);
    end
  endtask

  task automatic test_no_lanes_and_error;
    do_txn(1'b1, 32'h2000_0010, 32'hFFFF_FFFF, 4'h0, "store_be0");
    do_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, "load_out_of_window");
  endtask

  task automatic test_boundaries;
    do_txn(1'b0, 32'h2000_0FFF, 32'h0, 4'b1001, "last_word");
    do_txn(1'b1, 32'h2000_1000, 32'h1234_5678, 4'hF, "one_past_end");
    do_txn(1'b0, 32'h1FFF_FFFC, 32'h0, 4'hF, "below_base");
    do_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h8, "top_of_space");
  endtask

  task automatic test_back_to_back;
    logic [31:0] sec_word, cur;
    logic [7:0]  exp_byte;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h2000_0100; i_wdata = 32'h4433_2211; i_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_we = 1'b0; i_be = 4'h2; i_addr = BASE + {18'b0, 12'($urandom_range(0, 1023) << 2)};
      n_checks++;
      if (o_ready !== 1'b0 || o_mmio_we !== 1'b1 || o_mmio_addr !== 32'h2000_0100 + 32'(k) ||
          o_mmio_wdata !== 8'(8'h11 * (k + 1))) begin
        n_fail++;
        $display("FAIL b2b_first_beat%0d: got ready=%b we=%b addr=%h wdata=%h want 0 1 %h %h",
                 k, o_ready, o_mmio_we, o_mmio_addr, o_mmio_wdata, 32'h2000_0100 + 32'(k), 8'(8'h11 * (k + 1)));
      end
    end
    @(negedge i_clk);
    i_addr = BASE + {18'b0, 12'($urandom_range(0, 1023) << 2)};
    n_checks++;
    if (o_done !== 1'b1 || o_ready !== 1'b0 || o_mmio_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first_done: got done=%b ready=%b we=%b want 1 0 0", o_done, o_ready, o_mmio_we);
    end
    @(negedge i_clk);
    i_addr   = BASE + {18'b0, 12'($urandom_range(0, 1023) << 2)};
    sec_word = i_addr;
    cur      = sec_word + 32'd1;
    exp_byte = periph_mem[cur[11:0]];
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", o_ready); end
    @(negedge i_clk);
    i_req = 1'b0;
    n_checks++;
    if (o_mmio_re !== 1'b1 || o_mmio_addr !== cur || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_beat: got re=%b addr=%h done=%b want 1 %h 0", o_mmio_re, o_mmio_addr, o_done, cur);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_done !== 1'b1 || o_err !== 1'b0 || o_rdata !== {16'h0, exp_byte, 8'h0}) begin
      n_fail++;
      $display("FAIL b2b_second_done: got done=%b err=%b rdata=%h want 1 0 %h", o_done, o_err, o_rdata, {16'h0, exp_byte, 8'h0});
    end
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_mmio_re !== 1'b0 || o_mmio_we !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_not_queued: got ready=%b re=%b we=%b done=%b want 1 0 0 0", o_ready, o_mmio_re, o_mmio_we, o_done);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h2000_0200; i_wdata = 32'hCAFE_F00D; i_be = 4'hF;
    @(negedge i_clk);
    i_req = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_mmio_we !== 1'b1 || o_mmio_addr !== 32'h2000_0201) begin
      n_fail++; $display("FAIL rst_mid_beat2: got we=%b addr=%h want 1 20000201", o_mmio_we, o_mmio_addr);
    end
    #1 i_rstn = 1'b0;
    #1;
    n_checks++;
    if (o_mmio_we !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_drop: got we=%b done=%b want 0 0", o_mmio_we, o_done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_done !== 1'b0 || o_mmio_we !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_hold%0d: got done=%b we=%b want 0 0", c, o_done, o_mmio_we);
      end
    end
    i_rstn = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_mmio_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got ready=%b done=%b we=%b want 1 0 0", o_ready, o_done, o_mmio_we);
    end
    do_txn(1'b0, 32'h2000_0204, 32'h0, 4'hF, "load_after_reset");
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else                           a = BASE + 32'($urandom_range(0, 4095));
      do_txn(1'($urandom), a, $urandom, 4'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) periph_mem[i] = 8'($urandom);
    test_reset();
    test_store_full();
    test_load_single();
    test_load_sparse();
    test_no_lanes_and_error();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL final_idle: got ready=%b done=%b want 1 0", o_ready, o_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_byte_bridge.md
Name: mmio_byte_bridge

Overview:
- Sits between the CPU load/store unit and the byte-wide MMIO peripherals, such as the GPIO block.
- Accepts one 32-bit word request with byte enables and serialises it into one single-cycle byte transaction per enabled lane, in ascending lane order.
- Reassembles read bytes into a 32-bit word, then signals completion.
- Rejects requests outside the MMIO window with an error completion and no bus activity.

Parameters:
- MMIO_BASE, 32'h2000_0000, first byte address of the MMIO window.
- MMIO_SIZE, 32'h0000_1000, window size in bytes; a request is in range iff MMIO_BASE <= word address < MMIO_BASE + MMIO_SIZE.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset, asynchronous, active-low
- i_req  input  1  request strobe; sampled only while o_ready=1
- i_we  input  1  1=store, 0=load
- i_addr  input  32  byte address; bits [1:0] ignored, forced to 0
- i_wdata  input  32  store data; lane k = bits [8k+7:8k]
- i_be  input  4  byte enables, lane k = bit k
- o_ready  output  1  bridge idle, can accept
- o_done  output  1  one-cycle completion pulse
- o_err  output  1  valid with o_done; 1 = address out of window
- o_rdata  output  32  load result, valid with o_done
- o_mmio_addr  output  32  byte address of current bus beat
- o_mmio_wdata  output  8  write byte of current beat
- i_mmio_rdata  input  8  peripheral read byte, combinational in the same cycle as o_mmio_re
- o_mmio_we  output  1  write strobe, one cycle per beat
- o_mmio_re  output  1  read strobe, one cycle per beat

Behaviour:

Reset:
- State goes to IDLE.
- o_done, o_err, o_mmio_we and o_mmio_re are 0; o_rdata, o_mmio_addr and o_mmio_wdata are 0.
- o_ready is 1 after reset deassertion.
- Reset mid-operation abandons the request: no further beats, no o_done.

FSM states: IDLE, BEAT, DONE.
- o_ready = (state == IDLE), combinational.

IDLE:
- Acceptance requires i_req=1 at a clock edge. The acceptance cycle is T.
- On acceptance, latch the word address {i_addr[31:2],2'b00}, i_we, i_wdata and i_be, and clear the read-data accumulator.
- Out of range: go to DONE with err=1.
- i_be == 0: go to DONE with err=0.
- Otherwise: go to BEAT, lane pointer = lowest set bit of i_be.

BEAT (one cycle per enabled lane k, ascending):
- o_mmio_addr = word address + k.
- Store: o_mmio_we=1, o_mmio_wdata = latched lane k.
- Load: o_mmio_re=1, o_mmio_wdata=0; i_mmio_rdata is captured at the clock edge into accumulator lane k.
- Disabled lanes are skipped and cost zero cycles.
- After the highest enabled lane, go to DONE.
- Outside BEAT, o_mmio_we and o_mmio_re are 0. o_mmio_addr and o_mmio_wdata hold their last values; the peripheral must ignore them without a strobe.

DONE (one cycle):
- o_done=1 and o_err = latched error.
- o_rdata = accumulator, with disabled lanes reading 0. o_rdata is 0 for stores and errors.
- Next state is IDLE.
- o_rdata holds its value until the next acceptance.

Latency with n enabled lanes:
- Beats occupy cycles T+1..T+n.
- o_done at T+n+1; n=0 or error gives o_done at T+1.
- Earliest next acceptance is T+n+2.

Other rules:
- i_req while o_ready=0 is ignored and not queued.
- Changes to i_addr, i_wdata and i_be after acceptance have no effect.
- Window arithmetic uses 33-bit unsigned comparison, so MMIO_BASE+MMIO_SIZE = 2^32 does not wrap.

Test Plan:
- Store, i_addr=0x2000_0000, i_wdata=0xDDCCBBAA, i_be=4'hF:
  - -> beats T+1..T+4 with we=1 at addresses 0x2000_0000..0x2000_0003 carrying data AA, BB, CC, DD.
  - -> o_done at T+5 with o_err=0, o_ready back at T+6.
- Load, i_addr=0x2000_0004, i_be=4'h1, peripheral drives 0x5A:
  - -> single re beat at 0x2000_0004 on T+1.
  - -> o_done at T+2 with o_rdata=0x0000005A.
- Load, i_addr=0x2000_0003 (low bits ignored), i_be=4'b0101, rdata 0x11 then 0x33:
  - -> beats at 0x2000_0000 then 0x2000_0002.
  - -> o_rdata=0x00330011, o_done at T+3.
- Store with i_be=0, and separately load from 0x1000_0000 (outside window):
  - -> no we or re ever asserted.
  - -> o_done at T+1 with o_err=0 and o_err=1 respectively.
- Assert i_req continuously with changing addresses during a 4-beat store:
  - -> only the first request is executed.
  - -> the second is accepted only at the first cycle o_ready=1.
- Pull i_rstn low during beat 2 of a 4-lane store:
  - -> o_mmio_we drops immediately, no o_done.
  - -> after release, o_ready=1 and a new load completes normally.
